// File: rtl/code_decompressor_pkg.sv
// Shared types and address helpers for the code decompressor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package code_decompressor_pkg;

  typedef enum logic [2:0] {
    LOAD,
    IDLE,
    FETCH_CODE,
    DECODE,
    FETCH_RAW,
    RESP
  } state_t;

  // Bit 15 of a code selects dictionary (1) vs raw table (0).
  localparam int CODE_DICT_BIT = 15;
  // A raw code carries a 15-bit word offset into the raw table.
  localparam int RAW_OFS_W     = 15;

  // Byte address of dictionary entry idx inside the preload image.
  function automatic logic [31:0] dict_word_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

  // Each 32-bit code word packs two 16-bit codes, so one code word covers
  // an 8-byte (two instruction) slice of the instruction address space.
  function automatic logic [31:0] code_word_addr(input logic [31:0] base,
                                                 input logic [28:0] tag);
    return base + {1'b0, tag, 2'b00};
  endfunction

  // Byte address of a raw instruction word.
  function automatic logic [31:0] raw_word_addr(input logic [31:0] base,
                                                input logic [RAW_OFS_W-1:0] ofs);
    return base + {15'b0, ofs, 2'b00};
  endfunction

endpackage

// File: rtl/dict_ram.sv
// Dictionary storage: one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; contents have no reset and are rewritten by preload.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module dict_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/code_decompressor.sv
// Expands a dictionary-compressed code image to serve icache line-fill reads.
// Latency: buffer hit + dictionary code responds 2 cycles after acceptance;
//   each downstream read adds (mem wait + 1). Backpressure: requests wait in
//   LOAD and while busy; downstream reads hold mem_valid/mem_addr until mem_ready.
// Ports: clk/reset; req_* icache side (valid held until ready pulse);
//   mem_* instruction memory side; dict_loaded, dict_hits, raw_hits status.
module code_decompressor
  import code_decompressor_pkg::*;
#(
  parameter int          DICT_SIZE = 256,
  parameter logic [31:0] DICT_BASE = 32'h0007_FC00,
  parameter logic [31:0] CODE_BASE = 32'h0008_0000,
  parameter logic [31:0] RAW_BASE  = 32'h000C_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic [31:0] req_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        dict_loaded,
  output logic [31:0] dict_hits,
  output logic [31:0] raw_hits
);

  localparam int IDX_W = (DICT_SIZE > 1) ? $clog2(DICT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DICT_SIZE - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] load_cnt;
  logic [31:0]      code_buf;
  logic [28:0]      code_tag;
  logic             code_vld;
  logic             mem_done;
  logic             buf_hit;
  logic [15:0]      code;
  logic             dict_sel;
  logic [31:0]      dict_rdata;
  logic             dict_we;
  logic             issue;
  logic [31:0]      issue_addr;
  logic             unused_addr_bits;

  // Byte offset within the instruction word carries no information.
  assign unused_addr_bits = ^req_addr[1:0];

  assign mem_done  = mem_valid && mem_ready;
  assign buf_hit   = code_vld && (code_tag == req_addr[31:3]);
  assign code      = req_addr[2] ? code_buf[31:16] : code_buf[15:0];
  assign dict_sel  = code[CODE_DICT_BIT];
  assign dict_we   = (state == LOAD) && mem_done;
  assign req_ready = (state == RESP);

  dict_ram #(
    .DEPTH(DICT_SIZE),
    .AW   (IDX_W)
  ) u_dict_ram (
    .clk  (clk),
    .we   (dict_we),
    .waddr(load_cnt),
    .wdata(mem_rdata),
    .raddr(code[IDX_W-1:0]),
    .rdata(dict_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_addr = mem_addr;

    case (state)
      LOAD:       if (mem_done && (load_cnt == LAST_IDX)) state_next = IDLE;
      IDLE:       if (req_valid) state_next = buf_hit ? DECODE : FETCH_CODE;
      FETCH_CODE: if (mem_done) state_next = DECODE;
      DECODE:     state_next = dict_sel ? RESP : FETCH_RAW;
      FETCH_RAW:  if (mem_done) state_next = RESP;
      RESP:       state_next = IDLE;
      default:    state_next = LOAD;
    endcase

    // A new downstream read starts only when none is outstanding. In LOAD
    // this leaves one idle cycle between consecutive preload reads, so every
    // read is a distinct valid/ready handshake.
    if (!mem_valid) begin
      case (state_next)
        LOAD: begin
          issue      = 1'b1;
          issue_addr = dict_word_addr(DICT_BASE, 32'(load_cnt));
        end
        FETCH_CODE: begin
          issue      = 1'b1;
          issue_addr = code_word_addr(CODE_BASE, req_addr[31:3]);
        end
        FETCH_RAW: begin
          issue      = 1'b1;
          issue_addr = raw_word_addr(RAW_BASE, code[RAW_OFS_W-1:0]);
        end
        default: begin
          issue = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt    <= '0;
      dict_loaded <= 1'b0;
      code_buf    <= '0;
      code_tag    <= '0;
      code_vld    <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      req_rdata   <= '0;
      dict_hits   <= '0;
      raw_hits    <= '0;
    end else begin
      if (mem_done) begin
        mem_valid <= 1'b0;
      end else if (issue) begin
        mem_valid <= 1'b1;
        mem_addr  <= issue_addr;
      end

      if (dict_we) begin
        load_cnt <= load_cnt + 1'b1;
        if (load_cnt == LAST_IDX) begin
          dict_loaded <= 1'b1;
        end
      end

      if ((state == FETCH_CODE) && mem_done) begin
        code_buf <= mem_rdata;
        code_tag <= req_addr[31:3];
        code_vld <= 1'b1;
      end

      if ((state == DECODE) && dict_sel) begin
        req_rdata <= dict_rdata;
        dict_hits <= dict_hits + 32'd1;
      end

      if ((state == FETCH_RAW) && mem_done) begin
        req_rdata <= mem_rdata;
        raw_hits  <= raw_hits + 32'd1;
      end
    end
  end

endmodule
